// File: rtl/onchip_ram_pkg.sv
// Shared types and configuration helpers for the dual-port Avalon on-chip RAM.
package onchip_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;

  function automatic bit data_w_ok(input int w);
    return (w % 8) == 0;
  endfunction

endpackage

// File: rtl/onchip_ram_rd_pipe.sv
// Read-return delay line: valid, out-of-range flag and data, frozen while en_i is low.
module onchip_ram_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic              oor_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [LAT-1:0]             valid_q;
  logic [LAT-1:0]             oor_q;
  logic [LAT-1:0][DATA_W-1:0] data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      oor_q   <= '0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q[0] <= valid_i;
      oor_q[0]   <= oor_i;
      data_q[0]  <= data_i;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        oor_q[i]   <= oor_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  // Gating with the enable means a held stage is presented in exactly one enabled cycle.
  assign valid_o = valid_q[LAT-1] & en_i;
  assign data_o  = oor_q[LAT-1] ? '0 : data_q[LAT-1];

endmodule

// File: rtl/onchip_ram_dp_avalon.sv
// True dual-port on-chip RAM with two Avalon-MM slaves, pipelined reads and a post-reset clear sweep.
module onchip_ram_dp_avalon
  import onchip_ram_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                DEPTH          = 1024,
  parameter int                ADDR_W         = 10,
  parameter int                READ_LATENCY   = 1,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE     = '0,
  localparam int               BE_W           = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  input  logic              reset_req,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_chipselect,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [BE_W-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,
  output logic              s1_waitrequest,
  input  logic [ADDR_W-1:0] s2_address,
  input  logic              s2_chipselect,
  input  logic              s2_read,
  input  logic              s2_write,
  input  logic [BE_W-1:0]   s2_byteenable,
  input  logic [DATA_W-1:0] s2_writedata,
  output logic [DATA_W-1:0] s2_readdata,
  output logic              s2_readdatavalid,
  output logic              s2_waitrequest,
  output state_t            dbg_state
);

  if (!data_w_ok(DATA_W) || READ_LATENCY < LAT_MIN || READ_LATENCY > LAT_MAX) begin : g_bad_cfg
    $error("onchip_ram_dp_avalon: illegal DATA_W or READ_LATENCY");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       DEPTH_U   = 32'(DEPTH);

  logic en;
  assign en = clken & ~reset_req;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                clr_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_we     = 1'b0;
    case (state_q)
      CLEAR: begin
        if (en) begin
          clr_we = 1'b1;
          if (clr_addr_q == LAST_ADDR) state_d = READY;
          else                         clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  logic waitreq;
  assign waitreq        = reset | (state_q != READY) | ~en;
  assign s1_waitrequest = waitreq;
  assign s2_waitrequest = waitreq;
  assign dbg_state      = state_q;

  // A write wins over a simultaneous read on the same port: no read is issued.
  logic s1_wr_acc, s1_rd_acc, s2_wr_acc, s2_rd_acc;
  assign s1_wr_acc = s1_chipselect & s1_write & ~waitreq;
  assign s1_rd_acc = s1_chipselect & s1_read & ~s1_write & ~waitreq;
  assign s2_wr_acc = s2_chipselect & s2_write & ~waitreq;
  assign s2_rd_acc = s2_chipselect & s2_read & ~s2_write & ~waitreq;

  logic s1_inr, s2_inr;
  assign s1_inr = 32'(s1_address) < DEPTH_U;
  assign s2_inr = 32'(s2_address) < DEPTH_U;

  logic [BE_W-1:0][7:0] mem_q [DEPTH-1:0];
  logic [ADDR_W-1:0]    s1_ridx, s2_ridx;
  logic [DATA_W-1:0]    s1_rword, s2_rword;

  assign s1_ridx  = s1_inr ? s1_address : '0;
  assign s2_ridx  = s2_inr ? s2_address : '0;
  assign s1_rword = mem_q[s1_ridx];
  assign s2_rword = mem_q[s2_ridx];

  // s1 lane writes come last so they override s2 on a shared address and lane.
  always_ff @(posedge clk) begin
    if (clr_we) mem_q[clr_addr_q] <= INIT_VALUE;
    for (int b = 0; b < BE_W; b++) begin
      if (s2_wr_acc && s2_inr && s2_byteenable[b]) mem_q[s2_ridx][b] <= s2_writedata[8*b +: 8];
      if (s1_wr_acc && s1_inr && s1_byteenable[b]) mem_q[s1_ridx][b] <= s1_writedata[8*b +: 8];
    end
  end

  onchip_ram_rd_pipe #(.DATA_W(DATA_W), .LAT(READ_LATENCY)) u_rd_pipe_s1 (
    .clk_i   (clk),
    .rst_i   (reset),
    .en_i    (en),
    .valid_i (s1_rd_acc),
    .oor_i   (~s1_inr),
    .data_i  (s1_rword),
    .valid_o (s1_readdatavalid),
    .data_o  (s1_readdata)
  );

  onchip_ram_rd_pipe #(.DATA_W(DATA_W), .LAT(READ_LATENCY)) u_rd_pipe_s2 (
    .clk_i   (clk),
    .rst_i   (reset),
    .en_i    (en),
    .valid_i (s2_rd_acc),
    .oor_i   (~s2_inr),
    .data_i  (s2_rword),
    .valid_o (s2_readdatavalid),
    .data_o  (s2_readdata)
  );

endmodule

// File: tb/tb_onchip_ram_dp_avalon.sv
// Directed bench driving two RAM instances (A: 1024 words, latency 1; B: 1000 words, latency 2) in lockstep.
module tb_onchip_ram_dp_avalon;
  import onchip_ram_pkg::*;

  logic        clk = 1'b0;
  logic        reset, clken, reset_req;
  logic [9:0]  s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata;

  logic [31:0] a_s1_rd, a_s2_rd, b_s1_rd, b_s2_rd;
  logic        a_s1_v, a_s2_v, b_s1_v, b_s2_v;
  logic        a_s1_w, a_s2_w, b_s1_w, b_s2_w;
  state_t      a_state, b_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  onchip_ram_dp_avalon #(
    .DATA_W(32), .DEPTH(1024), .ADDR_W(10), .READ_LATENCY(1),
    .CLEAR_ON_RESET(1), .INIT_VALUE(32'hA5A5A5A5)
  ) dut_a (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(a_s1_rd), .s1_readdatavalid(a_s1_v), .s1_waitrequest(a_s1_w),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(a_s2_rd), .s2_readdatavalid(a_s2_v), .s2_waitrequest(a_s2_w),
    .dbg_state(a_state)
  );

  onchip_ram_dp_avalon #(
    .DATA_W(32), .DEPTH(1000), .ADDR_W(10), .READ_LATENCY(2),
    .CLEAR_ON_RESET(1), .INIT_VALUE(32'h0)
  ) dut_b (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(b_s1_rd), .s1_readdatavalid(b_s1_v), .s1_waitrequest(b_s1_w),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(b_s2_rd), .s2_readdatavalid(b_s2_v), .s2_waitrequest(b_s2_w),
    .dbg_state(b_state)
  );

  // ---------------- driver tasks ----------------
  task automatic idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
  endtask

  task automatic drive(input int p, input logic rd, input logic wr, input logic [9:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (p == 1) begin
      s1_chipselect = 1; s1_read = rd; s1_write = wr; s1_address = a; s1_byteenable = be; s1_writedata = d;
    end else begin
      s2_chipselect = 1; s2_read = rd; s2_write = wr; s2_address = a; s2_byteenable = be; s2_writedata = d;
    end
  endtask

  task automatic write_word(input int p, input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk); idle(); drive(p, 1'b0, 1'b1, a, be, d);
    @(negedge clk); idle();
  endtask

  // Issues one read on port p (optionally with an s1 write to the same address in the same
  // cycle) and reports first-valid latency, data and number of valids for both instances.
  task automatic do_read(input int p, input logic [9:0] a, input logic wr1, input logic [31:0] wd1,
                         output logic [31:0] da, output int la, output int na,
                         output logic [31:0] db, output int lb, output int nb);
    logic va, vb;
    @(negedge clk); idle(); drive(p, 1'b1, 1'b0, a, 4'h0, 32'h0);
    if (wr1) drive(1, 1'b0, 1'b1, a, 4'hF, wd1);
    la = 0; lb = 0; na = 0; nb = 0; da = '0; db = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) idle();
      #1;
      va = (p == 1) ? a_s1_v : a_s2_v;
      vb = (p == 1) ? b_s1_v : b_s2_v;
      if (va) begin if (na == 0) begin la = k; da = (p == 1) ? a_s1_rd : a_s2_rd; end na++; end
      if (vb) begin if (nb == 0) begin lb = k; db = (p == 1) ? b_s1_rd : b_s2_rd; end nb++; end
    end
  endtask

  // Counts cycles of waitrequest after reset release; clken is dropped for 10 cycles from pause_at.
  task automatic count_wait(input int pause_at, output int na, output int nb);
    na = -1; nb = -1;
    for (int k = 0; k < 1200; k++) begin
      clken = !(pause_at >= 0 && k >= pause_at && k < pause_at + 10);
      #1;
      if (!a_s1_w && na < 0) na = k;
      if (!b_s1_w && nb < 0) nb = k;
      if (na >= 0 && nb >= 0) break;
      @(negedge clk);
    end
    clken = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int na, nb;
    reset = 1; clken = 1; reset_req = 0; idle();
    repeat (3) @(negedge clk);
    #1;
    total++; if ({a_s1_w, a_s2_w, b_s1_w, b_s2_w} !== 4'hF) begin bad++;
      $display("FAIL reset_waitreq: got %b want 1111", {a_s1_w, a_s2_w, b_s1_w, b_s2_w}); end
    total++; if ({a_s1_v, a_s2_v, b_s1_v, b_s2_v} !== 4'h0) begin bad++;
      $display("FAIL reset_valid: got %b want 0000", {a_s1_v, a_s2_v, b_s1_v, b_s2_v}); end
    total++; if ({a_s1_rd, a_s2_rd, b_s1_rd, b_s2_rd} !== 128'h0) begin bad++;
      $display("FAIL reset_readdata: got %h want 0", {a_s1_rd, a_s2_rd, b_s1_rd, b_s2_rd}); end
    total++; if (a_state !== CLEAR || b_state !== CLEAR) begin bad++;
      $display("FAIL reset_state: got %0d/%0d want CLEAR", a_state, b_state); end
    @(negedge clk); reset = 0;
    count_wait(-1, na, nb);
    total++; if (na != 1024) begin bad++; $display("FAIL clear_len_a: got %0d want 1024", na); end
    total++; if (nb != 1000) begin bad++; $display("FAIL clear_len_b: got %0d want 1000", nb); end
    total++; if (a_state !== READY || b_state !== READY) begin bad++;
      $display("FAIL ready_state: got %0d/%0d want READY", a_state, b_state); end
  endtask

  task automatic test_clear_value();
    logic [31:0] da, db; int la, lb, na, nb;
    do_read(1, 10'h3FF, 1'b0, 32'h0, da, la, na, db, lb, nb);
    total++; if (da !== 32'hA5A5A5A5 || la != 1 || na != 1) begin bad++;
      $display("FAIL clear_read_a: got %h lat %0d n %0d want a5a5a5a5 lat 1 n 1", da, la, na); end
    total++; if (db !== 32'h0 || lb != 2 || nb != 1) begin bad++;
      $display("FAIL oor_read_b: got %h lat %0d n %0d want 0 lat 2 n 1", db, lb, nb); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] da, db; int la, lb, na, nb;
    write_word(1, 10'd5, 4'b0101, 32'h11223344);
    do_read(2, 10'd5, 1'b0, 32'h0, da, la, na, db, lb, nb);
    total++; if (da !== 32'hA522A544 || la != 1 || na != 1) begin bad++;
      $display("FAIL lanes_a: got %h lat %0d n %0d want a522a544 lat 1 n 1", da, la, na); end
    total++; if (db !== 32'h00220044 || lb != 2 || nb != 1) begin bad++;
      $display("FAIL lanes_b: got %h lat %0d n %0d want 00220044 lat 2 n 1", db, lb, nb); end
    write_word(2, 10'd5, 4'b0000, 32'hFFFFFFFF);
    do_read(1, 10'd5, 1'b0, 32'h0, da, la, na, db, lb, nb);
    total++; if (da !== 32'hA522A544 || db !== 32'h00220044) begin bad++;
      $display("FAIL be_zero: got %h/%h want a522a544/00220044", da, db); end
  endtask

  task automatic test_write_collision();
    logic [31:0] da, db; int la, lb, na, nb;
    @(negedge clk); idle();
    drive(1, 1'b0, 1'b1, 10'd7, 4'hF, 32'hDEADBEEF);
    drive(2, 1'b0, 1'b1, 10'd7, 4'hF, 32'h00000000);
    do_read(2, 10'd7, 1'b0, 32'h0, da, la, na, db, lb, nb);
    total++; if (da !== 32'hDEADBEEF || db !== 32'hDEADBEEF) begin bad++;
      $display("FAIL wr_collide_full: got %h/%h want deadbeef", da, db); end
    @(negedge clk); idle();
    drive(1, 1'b0, 1'b1, 10'd8, 4'b0011, 32'h11111111);
    drive(2, 1'b0, 1'b1, 10'd8, 4'b0110, 32'h22222222);
    do_read(1, 10'd8, 1'b0, 32'h0, da, la, na, db, lb, nb);
    total++; if (da !== 32'hA5221111 || db !== 32'h00221111) begin bad++;
      $display("FAIL wr_collide_lanes: got %h/%h want a5221111/00221111", da, db); end
  endtask

  task automatic test_read_before_write();
    logic [31:0] da, db; int la, lb, na, nb;
    do_read(2, 10'd9, 1'b1, 32'h0000CAFE, da, la, na, db, lb, nb);
    total++; if (da !== 32'hA5A5A5A5 || db !== 32'h0 || na != 1 || nb != 1) begin bad++;
      $display("FAIL rbw_old: got %h/%h n %0d/%0d want a5a5a5a5/0 n 1/1", da, db, na, nb); end
    do_read(2, 10'd9, 1'b0, 32'h0, da, la, na, db, lb, nb);
    total++; if (da !== 32'h0000CAFE || db !== 32'h0000CAFE) begin bad++;
      $display("FAIL rbw_new: got %h/%h want 0000cafe", da, db); end
  endtask

  task automatic test_rd_wr_both();
    logic [31:0] da, db; int la, lb, na, nb; int nv;
    @(negedge clk); idle(); drive(1, 1'b1, 1'b1, 10'd6, 4'hF, 32'h00000066);
    nv = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) idle();
      #1;
      if (a_s1_v) nv++;
      if (b_s1_v) nv++;
    end
    total++; if (nv != 0) begin bad++; $display("FAIL rdwr_no_valid: got %0d valids want 0", nv); end
    do_read(1, 10'd6, 1'b0, 32'h0, da, la, na, db, lb, nb);
    total++; if (da !== 32'h00000066 || db !== 32'h00000066) begin bad++;
      $display("FAIL rdwr_written: got %h/%h want 00000066", da, db); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ra [4];
    logic [31:0] rb [4];
    int idx, got_a, got_b, last_a, last_b;
    for (int i = 0; i < 4; i++) write_word(1, 10'(i), 4'hF, 32'hB0B00000 + 32'(i));
    idx = 0; got_a = 0; got_b = 0; last_a = -1; last_b = -1;
    for (int i = 0; i < 4; i++) begin ra[i] = '0; rb[i] = '0; end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      reset_req = (k == 2);
      idle();
      if (idx < 4) drive(1, 1'b1, 1'b0, 10'(idx), 4'h0, 32'h0);
      #1;
      if (a_s1_v) begin if (got_a < 4) ra[got_a] = a_s1_rd; got_a++; last_a = k; end
      if (b_s1_v) begin if (got_b < 4) rb[got_b] = b_s1_rd; got_b++; last_b = k; end
      if (idx < 4 && !a_s1_w) idx++;
    end
    reset_req = 0; idle();
    total++; if (got_a != 4 || got_b != 4) begin bad++;
      $display("FAIL b2b_count: got %0d/%0d want 4/4", got_a, got_b); end
    total++; if (last_a != 5 || last_b != 6) begin bad++;
      $display("FAIL b2b_last_cycle: got %0d/%0d want 5/6", last_a, last_b); end
    for (int i = 0; i < 4; i++) begin
      total++; if (ra[i] !== 32'hB0B00000 + 32'(i) || rb[i] !== 32'hB0B00000 + 32'(i)) begin bad++;
        $display("FAIL b2b_data[%0d]: got %h/%h want %h", i, ra[i], rb[i], 32'hB0B00000 + 32'(i)); end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] da, db; int la, lb, na, nb;
    write_word(1, 10'd1023, 4'hF, 32'h12345678);
    do_read(2, 10'd1023, 1'b0, 32'h0, da, la, na, db, lb, nb);
    total++; if (da !== 32'h12345678 || na != 1) begin bad++;
      $display("FAIL oor_inrange_a: got %h n %0d want 12345678 n 1", da, na); end
    total++; if (db !== 32'h0 || lb != 2 || nb != 1) begin bad++;
      $display("FAIL oor_dropped_b: got %h lat %0d n %0d want 0 lat 2 n 1", db, lb, nb); end
  endtask

  task automatic test_clear_restart();
    logic [31:0] da, db; int la, lb, na, nb; int ca, cb;
    @(negedge clk); reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (500) @(negedge clk);
    reset = 1;
    @(negedge clk); #1;
    total++; if (a_state !== CLEAR || b_state !== CLEAR || a_s1_w !== 1'b1) begin bad++;
      $display("FAIL restart_state: got %0d/%0d wait %b want CLEAR wait 1", a_state, b_state, a_s1_w); end
    reset = 0;
    count_wait(100, ca, cb);
    total++; if (ca != 1034 || cb != 1010) begin bad++;
      $display("FAIL restart_len: got %0d/%0d want 1034/1010", ca, cb); end
    do_read(1, 10'h3FF, 1'b0, 32'h0, da, la, na, db, lb, nb);
    total++; if (da !== 32'hA5A5A5A5) begin bad++;
      $display("FAIL restart_last_word: got %h want a5a5a5a5", da); end
    do_read(2, 10'd5, 1'b0, 32'h0, da, la, na, db, lb, nb);
    total++; if (da !== 32'hA5A5A5A5 || db !== 32'h0) begin bad++;
      $display("FAIL restart_refill: got %h/%h want a5a5a5a5/0", da, db); end
  endtask

  initial begin
    test_reset();
    test_clear_value();
    test_byte_lanes();
    test_write_collision();
    test_read_before_write();
    test_rd_wr_both();
    test_back_to_back();
    test_out_of_range();
    test_clear_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
